// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle: FIFO read port toward the async FIFO plus the
// downstream valid/ready stream. The drain stage owns the master side.
interface fifo_rd_stream_if #(
  parameter int unsigned DSIZE = 8
);
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;

  modport master (
    input  rdata,
    input  rempty,
    output rinc,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    output rdata,
    output rempty,
    input  rinc,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain drain stage: pops the async FIFO into a 2-entry skid buffer
// and presents the head as a registered valid/ready stream. The FIFO pop
// strobe looks only at local state, so m_ready never reaches rinc.
module fifo_rd_stream #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             flush,
  fifo_rd_stream_if.master bus,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q;
  logic [DSIZE-1:0] head_q;
  logic [DSIZE-1:0] tail_q;
  logic [CNT_W-1:0] cnt_q;

  logic push;
  logic pop;

  // Pop the FIFO whenever a word is there and a skid slot is free.
  assign push = ~bus.rempty & (state_q != TWO) & ~flush & ~rrst;
  assign pop  = (state_q != EMPTY) & bus.m_ready;

  assign bus.rinc    = push;
  assign bus.m_valid = (state_q != EMPTY);
  assign bus.m_data  = head_q;
  assign xfer_cnt    = cnt_q;

  // Skid buffer occupancy, head/tail data and transfer counter.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (pop) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flush) begin
        state_q <= EMPTY;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (push) begin
              state_q <= ONE;
              head_q  <= bus.rdata;
            end
          end
          ONE: begin
            if (push && !pop) begin
              state_q <= TWO;
              tail_q  <= bus.rdata;
            end else if (push && pop) begin
              head_q  <= bus.rdata;
            end else if (!push && pop) begin
              state_q <= EMPTY;
            end
          end
          TWO: begin
            if (pop) begin
              state_q <= ONE;
              head_q  <= tail_q;
            end
          end
          default: begin
            state_q <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and randomised checks for the FIFO read drain stage. The bench
// models the FIFO as a queue that is popped on every edge where rinc was high.
module tb_fifo_rd_stream;
  localparam int unsigned DSIZE = 8;
  localparam int unsigned CNT_W = 4;

  logic             rclk = 1'b0;
  logic             rrst;
  logic             flush;
  logic [CNT_W-1:0] xfer_cnt;

  fifo_rd_stream_if #(.DSIZE(DSIZE)) bus ();

  fifo_rd_stream #(.DSIZE(DSIZE), .CNT_W(CNT_W)) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .flush    (flush),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
  );

  always #5 rclk = ~rclk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] fifo_q[$];
  logic       hold_empty = 1'b0;

  // Present the modelled FIFO head on the read port.
  task automatic drive_fifo();
    bus.rempty = hold_empty || (fifo_q.size() == 0);
    bus.rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'hEE;
  endtask

  // Apply this cycle's inputs and let combinational outputs settle.
  task automatic setup(input logic ready, input logic fl);
    bus.m_ready = ready;
    flush       = fl;
    drive_fifo();
    #1;
  endtask

  // Advance one clock; the FIFO model pops if rinc was high before the edge.
  task automatic tick();
    logic r;
    r = bus.rinc;
    @(posedge rclk);
    if (r && fifo_q.size() != 0) fifo_q.delete(0);
    #1;
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    fifo_q.delete();
    fifo_q.push_back(8'hAA);
    setup(1'b1, 1'b0);
    n_checks++; if (bus.rinc !== 1'b0) $display("FAIL reset_rinc got %b want 0", bus.rinc); else n_pass++;
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h00) $display("FAIL reset_data got %h want 00", bus.m_data); else n_pass++;
    n_checks++; if (xfer_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", xfer_cnt); else n_pass++;
    tick();
    setup(1'b1, 1'b0);
    n_checks++; if (fifo_q.size() != 1) $display("FAIL reset_nopop got %0d words want 1", fifo_q.size()); else n_pass++;
    fifo_q.delete();
    drive_fifo();
    rrst = 1'b0;
    #1;
  endtask

  task automatic test_stream();
    logic [7:0] ed[5];
    logic       ev[5];
    logic       er[5];
    ed = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    fifo_q.push_back(8'h11);
    fifo_q.push_back(8'h22);
    fifo_q.push_back(8'h33);
    for (int c = 0; c < 5; c++) begin
      setup(1'b1, 1'b0);
      n_checks++; if (bus.rinc !== er[c]) $display("FAIL stream_rinc c%0d got %b want %b", c, bus.rinc, er[c]); else n_pass++;
      n_checks++; if (bus.m_valid !== ev[c]) $display("FAIL stream_valid c%0d got %b want %b", c, bus.m_valid, ev[c]); else n_pass++;
      if (ev[c]) begin
        n_checks++; if (bus.m_data !== ed[c]) $display("FAIL stream_data c%0d got %h want %h", c, bus.m_data, ed[c]); else n_pass++;
      end
      tick();
    end
    n_checks++; if (xfer_cnt !== 4'd3) $display("FAIL stream_cnt got %0d want 3", xfer_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    logic [7:0] ed[9];
    logic       ev[9];
    logic       er[9];
    logic       rdy[9];
    ed  = '{8'h00, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    ev  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    er  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 1; i <= 4; i++) fifo_q.push_back(8'(8'h11 * i));
    for (int c = 0; c < 9; c++) begin
      setup(rdy[c], 1'b0);
      n_checks++; if (bus.rinc !== er[c]) $display("FAIL stall_rinc c%0d got %b want %b", c, bus.rinc, er[c]); else n_pass++;
      n_checks++; if (bus.m_valid !== ev[c]) $display("FAIL stall_valid c%0d got %b want %b", c, bus.m_valid, ev[c]); else n_pass++;
      if (ev[c]) begin
        n_checks++; if (bus.m_data !== ed[c]) $display("FAIL stall_data c%0d got %h want %h", c, bus.m_data, ed[c]); else n_pass++;
      end
      tick();
    end
    n_checks++; if (xfer_cnt !== 4'd7) $display("FAIL stall_cnt got %0d want 7", xfer_cnt); else n_pass++;
  endtask

  task automatic test_flush();
    fifo_q.push_back(8'h55);
    fifo_q.push_back(8'h66);
    fifo_q.push_back(8'h77);
    fifo_q.push_back(8'h88);
    setup(1'b0, 1'b0); tick();
    setup(1'b0, 1'b0); tick();
    setup(1'b0, 1'b1);
    n_checks++; if (bus.rinc !== 1'b0) $display("FAIL flush_rinc got %b want 0", bus.rinc); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h55) $display("FAIL flush_pre_data got %h want 55", bus.m_data); else n_pass++;
    tick();
    setup(1'b0, 1'b0);
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", bus.m_valid); else n_pass++;
    n_checks++; if (bus.rinc !== 1'b1) $display("FAIL flush_resume got %b want 1", bus.rinc); else n_pass++;
    n_checks++; if (xfer_cnt !== 4'd7) $display("FAIL flush_cnt got %0d want 7", xfer_cnt); else n_pass++;
    tick();
    setup(1'b1, 1'b0);
    n_checks++; if (bus.m_data !== 8'h77) $display("FAIL flush_next got %h want 77", bus.m_data); else n_pass++;
    tick();
    setup(1'b1, 1'b0);
    n_checks++; if (bus.m_data !== 8'h88) $display("FAIL flush_last got %h want 88", bus.m_data); else n_pass++;
    tick();
    setup(1'b1, 1'b0);
    n_checks++; if (xfer_cnt !== 4'd9) $display("FAIL flush_cnt2 got %0d want 9", xfer_cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    // Reset in the middle of a transfer drops the buffer and pops nothing.
    fifo_q.push_back(8'h01);
    fifo_q.push_back(8'h02);
    setup(1'b0, 1'b0); tick();
    setup(1'b0, 1'b0);
    rrst = 1'b1;
    #1;
    n_checks++; if (bus.rinc !== 1'b0) $display("FAIL midrst_rinc got %b want 0", bus.rinc); else n_pass++;
    n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", bus.m_valid); else n_pass++;
    tick();
    n_checks++; if (fifo_q.size() != 1) $display("FAIL midrst_nopop got %0d words want 1", fifo_q.size()); else n_pass++;
    fifo_q.delete();
    drive_fifo();
    rrst = 1'b0;
    for (int i = 0; i < 17; i++) fifo_q.push_back(8'(i));
    for (int c = 0; c < 60 && n < 17; c++) begin
      setup(1'b1, 1'b0);
      if (bus.m_valid && bus.m_ready) begin
        n++;
        tick();
        if (n == 15) begin
          n_checks++; if (xfer_cnt !== 4'd15) $display("FAIL wrap_15 got %0d want 15", xfer_cnt); else n_pass++;
        end
        if (n == 16) begin
          n_checks++; if (xfer_cnt !== 4'd0) $display("FAIL wrap_16 got %0d want 0", xfer_cnt); else n_pass++;
        end
      end else begin
        tick();
      end
    end
    n_checks++; if (n != 17) $display("FAIL wrap_xfers got %0d want 17", n); else n_pass++;
    n_checks++; if (xfer_cnt !== 4'd1) $display("FAIL wrap_cnt got %0d want 1", xfer_cnt); else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] sb[$];
    logic [7:0] w;
    logic [7:0] pd;
    logic       pv;
    logic       pr;
    logic       exp_r;
    int         occ;
    w   = 8'h00;
    occ = 0;
    pv  = 1'b0;
    pr  = 1'b0;
    pd  = 8'h00;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) != 0 && fifo_q.size() < 8) begin
        fifo_q.push_back(w);
        sb.push_back(w);
        w = w + 8'd1;
      end
      hold_empty = ($urandom_range(0, 3) == 0);
      setup(1'($urandom_range(0, 1)), 1'b0);
      exp_r = !bus.rempty && (occ != 2);
      n_checks++; if (bus.rinc !== exp_r) $display("FAIL rand_rinc cyc%0d got %b want %b", i, bus.rinc, exp_r); else n_pass++;
      n_checks++; if (bus.m_valid !== (occ != 0)) $display("FAIL rand_valid cyc%0d got %b want %b", i, bus.m_valid, occ != 0); else n_pass++;
      if (pv && !pr) begin
        n_checks++; if (bus.m_data !== pd || bus.m_valid !== 1'b1) $display("FAIL rand_stable cyc%0d got %h/%b want %h/1", i, bus.m_data, bus.m_valid, pd); else n_pass++;
      end
      if (bus.m_valid && bus.m_ready) begin
        n_checks++;
        if (sb.size() == 0) $display("FAIL rand_order cyc%0d got %h want nothing", i, bus.m_data);
        else if (bus.m_data !== sb[0]) $display("FAIL rand_order cyc%0d got %h want %h", i, bus.m_data, sb[0]);
        else n_pass++;
        if (sb.size() != 0) sb.delete(0);
      end
      occ = occ + (bus.rinc ? 1 : 0) - ((bus.m_valid && bus.m_ready) ? 1 : 0);
      pv = bus.m_valid;
      pr = bus.m_ready;
      pd = bus.m_data;
      tick();
    end
    hold_empty = 1'b0;
    for (int c = 0; c < 100 && sb.size() != 0; c++) begin
      setup(1'b1, 1'b0);
      if (bus.m_valid) begin
        n_checks++;
        if (bus.m_data !== sb[0]) $display("FAIL drain_order got %h want %h", bus.m_data, sb[0]);
        else n_pass++;
        sb.delete(0);
      end
      tick();
    end
    n_checks++; if (sb.size() != 0) $display("FAIL drain_left got %0d words want 0", sb.size()); else n_pass++;
  endtask

  initial begin
    flush       = 1'b0;
    bus.m_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
